// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 multi-block sequencer.
// State encoding, block geometry and the SHA-256 initial hash value.
package sha256_pkg;

    localparam int WORD_W    = 32;
    localparam int BLK_WORDS = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        START = 3'd2,
        FEED  = 3'd3,
        WAIT  = 3'd4,
        DONE  = 3'd5
    } seq_state_t;

    // H0..H7, most significant word first
    localparam logic [8*WORD_W-1:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

endpackage

// File: rtl/sha256_blk_buf.sv
// One-block message buffer: synchronous write port, asynchronous read port.
// Contents are not reset; every word is rewritten before it is read.
module sha256_blk_buf
    import sha256_pkg::*;
#(
    parameter int WORDS = BLK_WORDS,
    localparam int AW = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  word_t         wdata,
    input  logic [AW-1:0] raddr,
    output word_t         rdata
);

    word_t mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sha256_block_seq.sv
// Multi-block sequencer: buffers one block from the host word stream,
// then starts, feeds and waits on the SHA-256 core once per block.
module sha256_block_seq
    import sha256_pkg::*;
#(
    parameter int WORDS = BLK_WORDS,
    parameter int CNT_W = 8,
    parameter int TMO   = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             msg_start,
    input  logic [CNT_W-1:0] n_blocks,
    input  logic             abort,
    input  logic             word_valid,
    input  logic [31:0]      word_data,
    output logic             word_ready,
    output logic             core_start,
    output logic             core_init,
    output logic             core_wvalid,
    output logic [31:0]      core_wdata,
    input  logic             core_busy,
    output logic             seq_busy,
    output logic [CNT_W-1:0] blk_cnt,
    output logic             msg_done,
    output logic             err
);

    localparam int IW = $clog2(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);
    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    seq_state_t       state;
    logic [IW-1:0]    widx;
    logic [IW-1:0]    ridx;
    logic [7:0]       tmo_cnt;
    logic [CNT_W-1:0] n_lat;
    logic [CNT_W-1:0] blk_nxt;
    word_t            rdata;
    word_t            wdata_q;
    logic             buf_we;
    logic             err_q;

    assign buf_we  = (state == FILL) && word_valid;
    assign blk_nxt = blk_cnt + CNT_W'(1);

    sha256_blk_buf #(
        .WORDS (WORDS)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (widx),
        .wdata (word_data),
        .raddr (ridx),
        .rdata (rdata)
    );

    // Everything the host and core see is decoded from registers only
    assign word_ready  = (state == FILL);
    assign core_start  = (state == START);
    assign core_init   = (state == START) && (blk_cnt == '0);
    assign core_wvalid = (state == FEED);
    assign core_wdata  = (state == FEED) ? rdata : wdata_q;
    assign seq_busy    = (state != IDLE);
    assign msg_done    = (state == DONE);
    assign err         = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            widx    <= '0;
            ridx    <= '0;
            tmo_cnt <= '0;
            n_lat   <= '0;
            blk_cnt <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (state == FEED) begin
                wdata_q <= rdata;
            end
            if (abort) begin
                state   <= IDLE;
                widx    <= '0;
                ridx    <= '0;
                tmo_cnt <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (msg_start) begin
                            if (n_blocks == '0) begin
                                err_q <= 1'b1;
                            end else begin
                                n_lat   <= n_blocks;
                                blk_cnt <= '0;
                                widx    <= '0;
                                state   <= FILL;
                            end
                        end
                    end
                    FILL: begin
                        if (word_valid) begin
                            if (widx == LAST) begin
                                widx  <= '0;
                                state <= START;
                            end else begin
                                widx <= widx + IW'(1);
                            end
                        end
                    end
                    START: begin
                        ridx  <= '0;
                        state <= FEED;
                    end
                    FEED: begin
                        if (ridx == LAST) begin
                            ridx    <= '0;
                            tmo_cnt <= '0;
                            state   <= WAIT;
                        end else begin
                            ridx <= ridx + IW'(1);
                        end
                    end
                    WAIT: begin
                        if (!core_busy) begin
                            blk_cnt <= blk_nxt;
                            state   <= (blk_nxt == n_lat) ? DONE : FILL;
                        end else if (tmo_cnt == TMO_LAST) begin
                            err_q   <= 1'b1;
                            tmo_cnt <= '0;
                            state   <= IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt + 8'd1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sha256_block_seq.sv
// Directed bench for sha256_block_seq with a simple busy-counter core model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_sha256_block_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        msg_start = 1'b0;
    logic [7:0]  n_blocks = '0;
    logic        abort = 1'b0;
    logic        word_valid = 1'b0;
    logic [31:0] word_data = '0;
    logic        word_ready;
    logic        core_start;
    logic        core_init;
    logic        core_wvalid;
    logic [31:0] core_wdata;
    logic        core_busy = 1'b0;
    logic        seq_busy;
    logic [7:0]  blk_cnt;
    logic        msg_done;
    logic        err;

    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sha256_block_seq #(
        .WORDS (16),
        .CNT_W (8),
        .TMO   (255)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .msg_start   (msg_start),
        .n_blocks    (n_blocks),
        .abort       (abort),
        .word_valid  (word_valid),
        .word_data   (word_data),
        .word_ready  (word_ready),
        .core_start  (core_start),
        .core_init   (core_init),
        .core_wvalid (core_wvalid),
        .core_wdata  (core_wdata),
        .core_busy   (core_busy),
        .seq_busy    (seq_busy),
        .blk_cnt     (blk_cnt),
        .msg_done    (msg_done),
        .err         (err)
    );

    // Core model: busy for busy_len cycles starting the cycle after core_start
    int busy_len = 64;
    int busy_left = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_busy <= 1'b0;
            busy_left <= 0;
        end else if (core_start) begin
            core_busy <= 1'b1;
            busy_left <= busy_len - 1;
        end else if (busy_left != 0) begin
            busy_left <= busy_left - 1;
        end else begin
            core_busy <= 1'b0;
        end
    end

    // Monitor
    logic        q_init [$];
    logic [31:0] q_word [$];
    int   cyc = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   done_cyc = 0;
    int   fall_cyc = 0;
    int   rdy_viol = 0;
    int   wait_busy = 0;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        prev_busy <= core_busy;
        if (core_start) q_init.push_back(core_init);
        if (core_wvalid) q_word.push_back(core_wdata);
        if (msg_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (err) err_cnt <= err_cnt + 1;
        if (prev_busy && !core_busy) fall_cyc <= cyc;
        if (word_ready && (core_wvalid || core_busy)) rdy_viol <= rdy_viol + 1;
        if (seq_busy && core_busy && !word_ready && !core_start &&
            !core_wvalid && !msg_done)
            wait_busy <= wait_busy + 1;
    end

    logic [31:0] blk_abc [16];
    logic [31:0] blk_a [16];
    logic [31:0] blk_b [16];
    logic [31:0] blk_c [16];
    logic [31:0] blk_e [16];
    logic [31:0] blk_f [16];

    task automatic send_word(input logic [31:0] d, input int gap);
        int n = 0;
        word_valid = 1'b1;
        word_data = d;
        while (!word_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (word_ready !== 1'b1) begin
            $display("FAIL word_ready_wait: ready=%0b required 1", word_ready);
            fails++;
        end
        @(negedge clk);
        word_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_block(input logic [31:0] w [16], input int gap);
        for (int i = 0; i < 16; i++) send_word(w[i], gap);
    endtask

    task automatic start_msg(input logic [7:0] n);
        msg_start = 1'b1;
        n_blocks = n;
        @(negedge clk);
        msg_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (seq_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (seq_busy !== 1'b0) begin
            $display("FAIL wait_idle: seq_busy=%0b required 0 after %0d cycles", seq_busy, budget);
            fails++;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic check_words(input string name, input int w0,
                               input logic [31:0] w [16]);
        int bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (q_word.size() <= w0 + i) bad++;
            else if (q_word[w0+i] !== w[i]) bad++;
        end
        checks++;
        if (bad != 0) begin
            $display("FAIL %s: %0d of 16 fed words wrong or missing, required 0", name, bad);
            fails++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({word_ready, core_start, core_init, core_wvalid, seq_busy, msg_done, err} !== 7'b0) begin
            $display("FAIL reset_flags: got %b required 0000000",
                     {word_ready, core_start, core_init, core_wvalid, seq_busy, msg_done, err});
            fails++;
        end
        checks++;
        if (core_wdata !== 32'h0) begin
            $display("FAIL reset_wdata: got %h required 00000000", core_wdata);
            fails++;
        end
        checks++;
        if (blk_cnt !== 8'h0) begin
            $display("FAIL reset_blk_cnt: got %0d required 0", blk_cnt);
            fails++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({seq_busy, word_ready} !== 2'b00) begin
            $display("FAIL reset_release: busy/ready=%b required 00", {seq_busy, word_ready});
            fails++;
        end
    endtask

    task automatic test_single_block(input string tag);
        int s0 = q_init.size();
        int w0 = q_word.size();
        int d0 = done_cnt;
        int e0 = err_cnt;
        int b0 = wait_busy;
        busy_len = 64;
        start_msg(8'd1);
        send_block(blk_abc, 0);
        wait_idle(500);
        checks++;
        if (q_init.size() - s0 != 1 || q_init[s0] !== 1'b1) begin
            $display("FAIL %s_start: %0d starts, first init=%b, required 1 start init=1",
                     tag, q_init.size() - s0, q_init[s0]);
            fails++;
        end
        checks++;
        if (q_word.size() - w0 != 16) begin
            $display("FAIL %s_nwords: got %0d required 16", tag, q_word.size() - w0);
            fails++;
        end
        check_words({tag, "_words"}, w0, blk_abc);
        checks++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
            $display("FAIL %s_pulses: done=%0d err=%0d required 1 and 0",
                     tag, done_cnt - d0, err_cnt - e0);
            fails++;
        end
        checks++;
        if (done_cyc != fall_cyc + 1) begin
            $display("FAIL %s_done_lat: done at %0d busy fell at %0d, required fall+1",
                     tag, done_cyc, fall_cyc);
            fails++;
        end
        checks++;
        if (wait_busy - b0 != 48) begin
            $display("FAIL %s_wait_cycles: got %0d required 48", tag, wait_busy - b0);
            fails++;
        end
        checks++;
        if (blk_cnt !== 8'd1) begin
            $display("FAIL %s_blk_cnt: got %0d required 1", tag, blk_cnt);
            fails++;
        end
    endtask

    task automatic test_two_blocks();
        int s0 = q_init.size();
        int w0 = q_word.size();
        int d0 = done_cnt;
        int r0 = rdy_viol;
        busy_len = 40;
        start_msg(8'd2);
        send_block(blk_a, 3);
        send_word(blk_b[0], 3);
        checks++;
        if (blk_cnt !== 8'd1 || done_cnt - d0 != 0) begin
            $display("FAIL two_mid: blk_cnt=%0d done=%0d required 1 and 0",
                     blk_cnt, done_cnt - d0);
            fails++;
        end
        for (int i = 1; i < 16; i++) send_word(blk_b[i], 3);
        wait_idle(2000);
        checks++;
        if (q_init.size() - s0 != 2 || q_init[s0] !== 1'b1 || q_init[s0+1] !== 1'b0) begin
            $display("FAIL two_init: %0d starts init=%b,%b required 2 starts 1,0",
                     q_init.size() - s0, q_init[s0], q_init[s0+1]);
            fails++;
        end
        check_words("two_words_a", w0, blk_a);
        check_words("two_words_b", w0 + 16, blk_b);
        checks++;
        if (rdy_viol - r0 != 0) begin
            $display("FAIL two_ready_busy: %0d cycles ready while feeding/waiting, required 0",
                     rdy_viol - r0);
            fails++;
        end
        checks++;
        if (done_cnt - d0 != 1 || blk_cnt !== 8'd2) begin
            $display("FAIL two_done: done=%0d blk_cnt=%0d required 1 and 2",
                     done_cnt - d0, blk_cnt);
            fails++;
        end
    endtask

    task automatic test_zero_and_ignore();
        int e0 = err_cnt;
        int s0, d0, n;
        msg_start = 1'b1;
        n_blocks = 8'd0;
        @(negedge clk);
        msg_start = 1'b0;
        checks++;
        if (err !== 1'b1 || seq_busy !== 1'b0) begin
            $display("FAIL zero_err: err=%0b busy=%0b required 1 and 0", err, seq_busy);
            fails++;
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || seq_busy !== 1'b0) begin
            $display("FAIL zero_after: err=%0b busy=%0b required 0 and 0", err, seq_busy);
            fails++;
        end
        #1;
        checks++;
        if (err_cnt - e0 != 1) begin
            $display("FAIL zero_pulse_len: %0d err cycles required 1", err_cnt - e0);
            fails++;
        end
        s0 = q_init.size();
        d0 = done_cnt;
        e0 = err_cnt;
        busy_len = 64;
        start_msg(8'd1);
        send_block(blk_abc, 0);
        n = 0;
        while (!(seq_busy && core_busy && !core_wvalid && !core_start) && n < 100) begin
            @(negedge clk);
            n++;
        end
        msg_start = 1'b1;
        n_blocks = 8'd5;
        @(negedge clk);
        msg_start = 1'b0;
        wait_idle(500);
        checks++;
        if (done_cnt - d0 != 1 || blk_cnt !== 8'd1 || q_init.size() - s0 != 1) begin
            $display("FAIL ignore_start: done=%0d blk_cnt=%0d starts=%0d required 1,1,1",
                     done_cnt - d0, blk_cnt, q_init.size() - s0);
            fails++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (seq_busy !== 1'b0 || err_cnt - e0 != 0) begin
            $display("FAIL ignore_idle: busy=%0b err=%0d required 0 and 0",
                     seq_busy, err_cnt - e0);
            fails++;
        end
    endtask

    task automatic test_timeout();
        int d0 = done_cnt;
        int e0 = err_cnt;
        int b0 = wait_busy;
        int n = 0;
        busy_len = 300;
        start_msg(8'd1);
        send_block(blk_c, 0);
        wait_idle(1000);
        checks++;
        if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
            $display("FAIL tmo_pulses: err=%0d done=%0d required 1 and 0",
                     err_cnt - e0, done_cnt - d0);
            fails++;
        end
        checks++;
        if (wait_busy - b0 != 255) begin
            $display("FAIL tmo_cycles: got %0d busy wait cycles required 255", wait_busy - b0);
            fails++;
        end
        checks++;
        if (blk_cnt !== 8'd0) begin
            $display("FAIL tmo_blk_cnt: got %0d required 0", blk_cnt);
            fails++;
        end
        while (core_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_abort();
        int d0 = done_cnt;
        int e0 = err_cnt;
        int s0, w0;
        busy_len = 64;
        start_msg(8'd1);
        for (int i = 0; i < 7; i++) send_word(32'hD000_0000 | 32'(i), 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (seq_busy !== 1'b0 || word_ready !== 1'b0) begin
            $display("FAIL abort_idle: busy=%0b ready=%0b required 0 and 0", seq_busy, word_ready);
            fails++;
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (done_cnt - d0 != 0 || err_cnt - e0 != 0) begin
            $display("FAIL abort_pulses: done=%0d err=%0d required 0 and 0",
                     done_cnt - d0, err_cnt - e0);
            fails++;
        end
        msg_start = 1'b1;
        abort = 1'b1;
        n_blocks = 8'd1;
        @(negedge clk);
        msg_start = 1'b0;
        abort = 1'b0;
        checks++;
        if (seq_busy !== 1'b0) begin
            $display("FAIL abort_vs_start: busy=%0b required 0", seq_busy);
            fails++;
        end
        s0 = q_init.size();
        w0 = q_word.size();
        d0 = done_cnt;
        start_msg(8'd1);
        send_block(blk_e, 0);
        wait_idle(500);
        check_words("abort_next_words", w0, blk_e);
        checks++;
        if (q_init.size() - s0 != 1 || q_init[s0] !== 1'b1 || done_cnt - d0 != 1) begin
            $display("FAIL abort_next: starts=%0d init=%b done=%0d required 1,1,1",
                     q_init.size() - s0, q_init[s0], done_cnt - d0);
            fails++;
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        busy_len = 64;
        start_msg(8'd1);
        send_block(blk_f, 0);
        while (!core_wvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({word_ready, core_start, core_init, core_wvalid, seq_busy, msg_done, err} !== 7'b0 ||
            core_wdata !== 32'h0 || blk_cnt !== 8'h0) begin
            $display("FAIL reset_mid: flags=%b wdata=%h blk_cnt=%0d required all 0",
                     {word_ready, core_start, core_init, core_wvalid, seq_busy, msg_done, err},
                     core_wdata, blk_cnt);
            fails++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_single_block("after_reset");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            blk_abc[i] = 32'h0;
            blk_a[i] = 32'(i + 1) * 32'h0101_0101;
            blk_b[i] = 32'hA000_0000 | 32'(i);
            blk_c[i] = 32'hC000_0000 | 32'(i);
            blk_e[i] = 32'hE000_0000 + 32'(i * 3);
            blk_f[i] = 32'hF000_0000 | 32'(i + 1);
        end
        blk_abc[0] = 32'h6162_6380;
        blk_abc[15] = 32'h0000_0018;
        repeat (2) @(negedge clk);
        test_reset();
        test_single_block("single");
        test_two_blocks();
        test_zero_and_ignore();
        test_timeout();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
